// File: rtl/fxp_alu_cmd_sequencer.sv
// fxp_alu_cmd_sequencer: FIFO-buffered command front-end with a registered result stage for a combinational fixed-point ALU.
// Optional overflow flag output res_ovf is built when FXP_SEQ_OVF_EN is defined.
module fxp_alu_cmd_sequencer #(
    parameter int N     = 32,
    parameter int Q     = 12,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   cmd_op,
    input  logic [N-1:0] cmd_a,
    input  logic [N-1:0] cmd_b,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [1:0]   alu_op,
    input  logic [N-1:0] alu_out,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [N-1:0] res_data,
    output logic [1:0]   res_op,
`ifdef FXP_SEQ_OVF_EN
    output logic         res_ovf,
`endif
    output logic         busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int W  = 2 * N + 2;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count;
    logic          push, pop, empty;
    logic          unused_cfg;

    assign unused_cfg = (Q < N);

    always_comb begin
        empty     = count == '0;
        cmd_ready = count != (AW + 1)'(DEPTH);
        push      = cmd_valid & cmd_ready;
        pop       = !empty & (!res_valid | res_ready);
        {alu_op, alu_a, alu_b} = empty ? '0 : mem[rptr];
        busy      = !empty | res_valid;
    end

    always_ff @(posedge clk)
        if (push) mem[wptr] <= {cmd_op, cmd_a, cmd_b};

`ifdef FXP_SEQ_OVF_EN
    logic ovf_next, sa, sb, so;
    always_comb begin
        sa       = alu_a[N-1];
        sb       = alu_b[N-1];
        so       = alu_out[N-1];
        ovf_next = (alu_op == 2'b00) ? (sa == sb) & (so != sa) :
                   (alu_op == 2'b01) ? (sa != sb) & (so != sa) : 1'b0;
    end

    always_ff @(posedge clk)
        if (!rst_n) res_ovf <= 1'b0;
        else if (pop) res_ovf <= ovf_next;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_op    <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            count <= count + (AW + 1)'(push) - (AW + 1)'(pop);
            if (pop) begin
                rptr      <= rptr + 1'b1;
                res_data  <= alu_out;
                res_op    <= alu_op;
                res_valid <= 1'b1;
            end else if (res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fxp_alu_cmd_sequencer.sv
// tb_fxp_alu_cmd_sequencer: directed bench for fxp_alu_cmd_sequencer with a behavioural Q20.12 ALU attached.
module tb_fxp_alu_cmd_sequencer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_a, cmd_b;
    logic [31:0] alu_a, alu_b, alu_out;
    logic [1:0]  alu_op;
    logic        res_valid, res_ready;
    logic [31:0] res_data;
    logic [1:0]  res_op;
    logic        busy;
`ifdef FXP_SEQ_OVF_EN
    logic        res_ovf;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_f(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] p;
        p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        return (op == 2'b00) ? a + b : (op == 2'b01) ? a - b : 32'(p >>> 12);
    endfunction

    assign alu_out = alu_f(alu_op, alu_a, alu_b);

    fxp_alu_cmd_sequencer #(.N(32), .Q(12), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_op(res_op),
`ifdef FXP_SEQ_OVF_EN
        .res_ovf(res_ovf),
`endif
        .busy(busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        cmd_valid = v;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
    endtask

    logic [33:0] exp_q[$];
    logic [33:0] e;
    int accepts, recv, seen;
    logic [1:0]  w_op [12];
    logic [31:0] w_a [12], w_b [12];

    initial begin
        rst_n = 1'b0;
        res_ready = 1'b0;
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_res_op", res_op, 0);
        check("rst_alu_a_empty", alu_a, 0);
        check("rst_alu_op_empty", alu_op, 0);
        rst_n = 1'b1;

        // add on an idle pipe: accepted at the first edge, result visible after the second
        res_ready = 1'b1;
        drive(1'b1, 2'b00, 32'h0000_1800, 32'h0000_2000);
        @(negedge clk);
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        check("add_cycle1_valid", res_valid, 0);
        check("add_head_a", alu_a, 32'h0000_1800);
        check("add_head_b", alu_b, 32'h0000_2000);
        @(negedge clk);
        check("add_cycle2_valid", res_valid, 1);
        check("add_data", res_data, 32'h0000_3800);
        check("add_op", res_op, 2'b00);
        @(negedge clk);
        check("add_drained", res_valid, 0);
        check("add_idle_busy", busy, 0);

        // back-to-back sub then mult
        drive(1'b1, 2'b01, 32'h0000_1800, 32'h0000_2000);
        @(negedge clk);
        drive(1'b1, 2'b10, 32'h0000_1800, 32'h0000_2000);
        @(negedge clk);
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        check("sub_valid", res_valid, 1);
        check("sub_data", res_data, 32'hFFFF_F800);
        check("sub_op", res_op, 2'b01);
        @(negedge clk);
        check("mul_valid", res_valid, 1);
        check("mul_data", res_data, 32'h0000_3000);
        check("mul_op", res_op, 2'b10);
        @(negedge clk);
        check("stream_drained", res_valid, 0);

        // full backpressure: DEPTH in the FIFO plus one held in the result register
        res_ready = 1'b0;
        accepts = 0;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 2'(accepts), 32'h1000 * (accepts + 1), 32'h0000_1000);
            if (cmd_ready) begin
                exp_q.push_back({cmd_op, alu_f(cmd_op, cmd_a, cmd_b)});
                accepts++;
            end
            @(negedge clk);
        end
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        check("bp_accepts", accepts, 5);
        check("bp_cmd_ready", cmd_ready, 0);
        check("bp_busy", busy, 1);
        res_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            e = exp_q.pop_front();
            check("bp_valid", res_valid, 1);
            check("bp_data", res_data, e[31:0]);
            check("bp_op", res_op, e[33:32]);
            @(negedge clk);
        end
        check("bp_drained", res_valid, 0);

        // wrap-around with random stalls on both handshakes
        for (int i = 0; i < 12; i++) begin
            w_op[i] = 2'(i);
            w_a[i]  = 32'h0000_0800 * (i + 1);
            w_b[i]  = (i % 2 == 1) ? 32'hFFFF_F000 : 32'h0000_3000;
        end
        accepts = 0;
        recv = 0;
        for (int cyc = 0; cyc < 500 && recv < 12; cyc++) begin
            if (accepts < 12 && $urandom_range(0, 3) != 0)
                drive(1'b1, w_op[accepts], w_a[accepts], w_b[accepts]);
            else
                drive(1'b0, 2'b00, 32'h0, 32'h0);
            res_ready = $urandom_range(0, 2) != 0;
            if (cmd_valid && cmd_ready) begin
                exp_q.push_back({cmd_op, alu_f(cmd_op, cmd_a, cmd_b)});
                accepts++;
            end
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    check("wrap_unexpected_result", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("wrap_data", res_data, e[31:0]);
                    check("wrap_op", res_op, e[33:32]);
                end
                recv++;
            end
            @(negedge clk);
        end
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        res_ready = 1'b1;
        check("wrap_received", recv, 12);
        @(negedge clk);
        check("wrap_idle", busy, 0);

        // reset while three commands queued and a result held
        res_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'b00, 32'h0000_1000 * (i + 1), 32'h0000_1000);
            @(negedge clk);
        end
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        @(negedge clk);
        check("prerst_valid", res_valid, 1);
        check("prerst_busy", busy, 1);
        rst_n = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_valid", res_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_cmd_ready", cmd_ready, 1);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (res_valid) seen++;
            @(negedge clk);
        end
        check("midrst_no_stale", seen, 0);

`ifdef FXP_SEQ_OVF_EN
        drive(1'b1, 2'b00, 32'h7FFF_F000, 32'h0000_1000);
        @(negedge clk);
        drive(1'b1, 2'b00, 32'h0000_1800, 32'h0000_2000);
        @(negedge clk);
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        check("ovf_data", res_data, 32'h8000_0000);
        check("ovf_flag", res_ovf, 1);
        @(negedge clk);
        check("noovf_data", res_data, 32'h0000_3800);
        check("noovf_flag", res_ovf, 0);
        @(negedge clk);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
